rv_decode_stage: RTL
====================

// Module: rv_decode_stage
// PURPOSE
//  Registered RV32I decode stage (ID) with a valid/ready handshake on both sides.
//  Sits between the fetch stage (IF) and the execute stage (EX), and emits one decoded bundle per accepted instruction.
//  New relative to the purely combinational decoder:
//   - optional M-extension decode;
//   - illegal-instruction detection;
//   - rd==x0 write suppression;
//   - load-use interlock (bubble insertion);
//   - flush;
//   - stall counter.
// PARAMETERS
//  ENABLE_M   1   1: funct7=0x01 on OP is legal and sets out_muldiv; 0: it is illegal.
//  CNT_W      16  Width of stall_cnt.
// PORTS
//  clk           in   1   Clock. Single clock domain.
//  reset         in   1   Synchronous, active-high reset.
//  flush         in   1   Discard the held bundle and any incoming instruction this cycle.
//  in_valid      in   1   IF offers an instruction.
//  in_ready      out  1   ID accepts the instruction this cycle.
//  in_instr      in   32  Raw instruction word.
//  in_pc         in   32  PC of in_instr.
//  out_valid     out  1   Decoded bundle is valid.
//  out_ready     in   1   EX takes the bundle this cycle.
//  out_pc        out  32  Registered copy of in_pc.
//  out_opcode    out  7   Opcode field.
//  out_rd        out  5   Destination register field.
//  out_rs1       out  5   Source register 1 field.
//  out_rs2       out  5   Source register 2 field.
//  out_funct3    out  3   funct3 field.
//  out_funct7    out  7   funct7 field.
//  out_imm       out  32  Immediate, sign-extended per format.
//  out_we        out  1   Writes rd.
//  out_load      out  1   Load.
//  out_store     out  1   Store.
//  out_branch    out  1   Conditional branch.
//  out_jal       out  1   JAL or JALR.
//  out_rs1_only  out  1   Reads rs1 only (rs2 unused).
//  out_muldiv    out  1   M-extension op.
//  out_ecall     out  1   ECALL.
//  out_illegal   out  1   Illegal instruction.
//  stall_cnt     out  CNT_W  Number of load-use bubbles inserted; saturates at the maximum.
// BEHAVIOUR
//  Reset:
//   - All out_* registers are 0; out_valid=0.
//   - stall_cnt=0.
//   - Load-use tracker cleared.
//   - in_ready=0 during the reset cycle.
//  Handshake:
//   - in_ready = !reset & !flush & !hazard & (!out_valid | out_ready).
//   - A transfer happens on in_valid & in_ready.
//   - Latency: one cycle; the bundle is registered on the next edge.
//   - out_* hold stable while out_valid & !out_ready.
//   - If out_ready & !(in_valid & in_ready), out_valid drops to 0 on the next edge.
//  Decode (combinational, on in_instr):
//   - I, S, B, U and J immediates per the RV32I formats, sign-extended from bit 31.
//   - Shift-immediate: imm[11:5]=0, imm[4:0]=shamt.
//   - Fields not used by a format carry the raw instruction bits in the same positions (rd=instr[11:7], etc.).
//   - LUI forces rs1=0.
//  Write enable:
//   - out_we=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, and only when rd!=0.
//   - out_we=0 for every other instruction.
//  Illegal instruction (out_illegal=1, all other control bits 0):
//   - Unknown opcode.
//   - OP with funct7 not in {0x00, 0x20, 0x01 if ENABLE_M}.
//   - OP with funct7=0x20 and funct3 not in {000, 101}.
//   - OP-IMM SLLI with funct7!=0; SRLI/SRAI with funct7 not in {0x00, 0x20}.
//   - LOAD with funct3 in {011, 110, 111}.
//   - STORE with funct3>=011.
//   - BRANCH with funct3 in {010, 011}.
//   - JALR with funct3!=000.
//   - SYSTEM other than exactly 0x00000073.
//  Load-use tracker:
//   - On every output handoff (out_valid & out_ready), latch ld_pend = out_load & out_we and ld_rd = out_rd.
//   - Any other cycle clears ld_pend.
//   - hazard = ld_pend & in_valid & !illegal & ((rs1 uses rd) | (rs2 uses rd)).
//   - "Uses" respects rs1_only, and LUI/JAL read no source registers.
//   - On hazard, in_ready=0 for exactly one cycle.
//   - The bubble (out_valid=0) appears on the next cycle; stall_cnt increments by 1.
//  Flush:
//   - On the next edge, out_valid=0 and ld_pend=0.
//   - The incoming instruction is not accepted.
//   - Flush takes priority over the handshake and the hazard.
//   - stall_cnt is unchanged.
//  Simultaneous events:
//   - Reset beats flush; flush beats hazard; hazard beats accept.
//   - Mid-stream reset drops the held bundle; no partial output.
// STRUCTURE
//  Package rv_pkg:
//   - Opcode localparams (OP, OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM).
//   - Immediate-format enum (I, S, B, U, J, NONE).
//   - Packed struct dec_ctrl_t holding the control bits.
//  Sub-module rv_decode_comb:
//   - Purely combinational: instr -> fields, imm, dec_ctrl_t, illegal.
//   - Parameter ENABLE_M.
//  rv_decode_stage (this block):
//   - Pipeline register.
//   - Handshake.
//   - Load-use tracker.
//   - stall_cnt.
// TESTING
//  1. 0xFFF00093 (addi x1,x0,-1) -> next cycle:
//     out_rd=1, out_imm=0xFFFFFFFF, out_we=1, out_rs1_only=1.
//  2. 0x00000013 (addi x0,x0,0) -> out_we=0, out_illegal=0.
//     0x00000000 -> out_illegal=1, out_we=0.
//  3. 0xFE208EE3 (beq x1,x2,-4) -> out_imm=0xFFFFFFFC, out_branch=1, out_we=0.
//  4. 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1), out_ready=1:
//     -> one out_valid=0 cycle between them; stall_cnt=1.
//     Same sequence with 0x001302B3 (add x5,x6,x1) as the second instruction -> no bubble.
//  5. 0x022081B3 (mul x3,x1,x2):
//     - ENABLE_M=1 -> out_muldiv=1, out_we=1.
//     - ENABLE_M=0 -> out_illegal=1.
//  6. Hold out_ready=0 for 3 cycles -> in_ready=0 and out_* stable.
//     Then assert flush -> out_valid=0 next cycle and the input is not consumed.
//     Reset during a load-use stall -> stall_cnt=0 and out_valid=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Package rv_pkg
// Shared RV32I decode definitions: opcode constants, immediate format enum,
// the decoded control-bit struct and an immediate generator helper.
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic we;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic rs1_only;
        logic muldiv;
        logic ecall;
    } dec_ctrl_t;

    // Sign-extended immediate for the given RV32I format.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Module rv_decode_comb
// Purely combinational RV32I (+ optional M) instruction decoder.
// Ports:
//   instr    in   32  raw instruction word
//   opcode, rd, rs1, rs2, funct3, funct7  out  raw fields (rs1 forced to 0 for LUI)
//   imm      out  32  sign-extended immediate (0 for formats without one)
//   ctrl     out      dec_ctrl_t control bits, all 0 when illegal
//   illegal  out  1   instruction is not a recognised encoding
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output dec_ctrl_t   ctrl,
    output logic        illegal
);

    imm_fmt_e  fmt;
    dec_ctrl_t raw_ctrl;
    logic      legal;
    logic      is_shift_imm;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign rs1    = (opcode == LUI) ? 5'd0 : instr[19:15];

    // SLLI/SRLI/SRAI carry the shift amount in imm[4:0]; funct7 is not part of the immediate.
    assign is_shift_imm = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);
    assign imm = is_shift_imm ? {27'd0, instr[24:20]} : imm_gen(instr, fmt);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        fmt      = FMT_NONE;
        raw_ctrl = '0;
        legal    = 1'b0;
        case (opcode)
            OP: begin
                legal = (funct7 == 7'h00)
                      || ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                      || (ENABLE_M && (funct7 == 7'h01));
                raw_ctrl.we     = 1'b1;
                raw_ctrl.muldiv = (funct7 == 7'h01);
            end
            OP_IMM: begin
                fmt = FMT_I;
                if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else                       legal = 1'b1;
                raw_ctrl.we       = 1'b1;
                raw_ctrl.rs1_only = 1'b1;
            end
            LOAD: begin
                fmt   = FMT_I;
                legal = !(funct3 inside {3'b011, 3'b110, 3'b111});
                raw_ctrl.we       = 1'b1;
                raw_ctrl.load     = 1'b1;
                raw_ctrl.rs1_only = 1'b1;
            end
            STORE: begin
                fmt   = FMT_S;
                legal = (funct3 < 3'b011);
                raw_ctrl.store = 1'b1;
            end
            BRANCH: begin
                fmt   = FMT_B;
                legal = !(funct3 inside {3'b010, 3'b011});
                raw_ctrl.branch = 1'b1;
            end
            JALR: begin
                fmt   = FMT_I;
                legal = (funct3 == 3'b000);
                raw_ctrl.we       = 1'b1;
                raw_ctrl.jal      = 1'b1;
                raw_ctrl.rs1_only = 1'b1;
            end
            JAL: begin
                fmt   = FMT_J;
                legal = 1'b1;
                raw_ctrl.we  = 1'b1;
                raw_ctrl.jal = 1'b1;
            end
            LUI, AUIPC: begin
                fmt   = FMT_U;
                legal = 1'b1;
                raw_ctrl.we = 1'b1;
            end
            SYSTEM: begin
                legal = (instr == INSTR_ECALL);
                raw_ctrl.ecall = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Writes to x0 are architecturally discarded, so never signal them.
        raw_ctrl.we = raw_ctrl.we && (rd != 5'd0);
    end

    assign illegal = !legal;
    assign ctrl    = legal ? raw_ctrl : '0;

endmodule

// File: rtl/rv_decode_stage.sv
// Module rv_decode_stage
// Registered RV32I decode stage between IF and EX with valid/ready on both sides,
// load-use interlock (one bubble), flush and a saturating bubble counter.
// Ports:
//   clk, reset (sync, active-high), flush
//   in_valid / in_ready / in_instr / in_pc        : IF side
//   out_valid / out_ready / out_*                  : EX side, registered decoded bundle
//   stall_cnt [CNT_W]                              : load-use bubbles inserted (saturating)
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_we,
    output logic             out_load,
    output logic             out_store,
    output logic             out_branch,
    output logic             out_jal,
    output logic             out_rs1_only,
    output logic             out_muldiv,
    output logic             out_ecall,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    dec_ctrl_t   dec_ctrl;
    logic        dec_illegal;

    dec_ctrl_t   out_ctrl;

    logic        handoff;
    logic        ld_pend;
    logic [4:0]  ld_rd;
    logic        reads_rs1;
    logic        reads_rs2;
    logic        hazard;
    logic        accept;
    logic        count_stall;

    rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .instr   (in_instr),
        .opcode  (dec_opcode),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .funct3  (dec_funct3),
        .funct7  (dec_funct7),
        .imm     (dec_imm),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Load-use tracker: the load leaving ID this cycle. A dependent instruction
    // offered in the same cycle is held for one cycle, which lets the load's
    // data arrive before the consumer reaches EX.
    assign handoff = out_valid && out_ready;
    assign ld_pend = handoff && out_ctrl.load && out_ctrl.we;
    assign ld_rd   = out_rd;

    assign reads_rs1 = (dec_opcode != LUI) && (dec_opcode != JAL);
    assign reads_rs2 = reads_rs1 && !dec_ctrl.rs1_only;

    assign hazard = ld_pend && in_valid && !dec_illegal
                 && ((reads_rs1 && (dec_rs1 == ld_rd)) || (reads_rs2 && (dec_rs2 == ld_rd)));

    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Flush suppresses the bubble count; the counter saturates at all-ones.
    assign count_stall = hazard && !flush && (stall_cnt != '1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the payload flops are reset as well so every out_* reads 0 after reset.
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_imm     <= '0;
            out_ctrl    <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_opcode  <= dec_opcode;
                out_rd      <= dec_rd;
                out_rs1     <= dec_rs1;
                out_rs2     <= dec_rs2;
                out_funct3  <= dec_funct3;
                out_funct7  <= dec_funct7;
                out_imm     <= dec_imm;
                out_ctrl    <= dec_ctrl;
                out_illegal <= dec_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (count_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign out_we       = out_ctrl.we;
    assign out_load     = out_ctrl.load;
    assign out_store    = out_ctrl.store;
    assign out_branch   = out_ctrl.branch;
    assign out_jal      = out_ctrl.jal;
    assign out_rs1_only = out_ctrl.rs1_only;
    assign out_muldiv   = out_ctrl.muldiv;
    assign out_ecall    = out_ctrl.ecall;

endmodule
